// File: rtl/test_sequencer.sv
`timescale 1ns/1ps
// Test sequencer: holds the cores in reset, waits for every core to jam (or the
// watchdog to expire), lets them settle, then captures per-core X/Y results.
module test_sequencer #(
  parameter int N_CORES        = 1,
  parameter int RST_CYCLES     = 2,
  parameter int SETTLE_CYCLES  = 50,
  parameter int TIMEOUT_CYCLES = 2500,
  localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [N_CORES-1:0]     i_jam,
  input  logic [8*N_CORES-1:0]   i_x,
  input  logic [8*N_CORES-1:0]   i_y,
  output logic                   o_core_rst,
  output logic                   o_done,
  output logic                   o_pass,
  output logic                   o_timeout,
  output logic [N_CORES-1:0]     o_fail_mask,
  output logic [8*N_CORES-1:0]   o_ntests,
  output logic [8*N_CORES-1:0]   o_exit_code,
  output logic [CNT_W-1:0]       o_elapsed
);

  localparam int PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  RST_LAST    = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_V   = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {HOLD, RUN, SETTLE, DONE} state_e;

  state_e               state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [N_CORES-1:0]   jam_seen_q, jam_seen_d;
  logic [CNT_W-1:0]     elapsed_q, elapsed_d;
  logic                 core_rst_q, core_rst_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic [N_CORES-1:0]   fail_q, fail_d;
  logic [8*N_CORES-1:0] ntests_q, ntests_d;
  logic [8*N_CORES-1:0] exit_q, exit_d;
  logic                 capture;
  logic [N_CORES-1:0]   cap_fail;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    jam_seen_d = jam_seen_q;
    elapsed_d  = elapsed_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    fail_d     = fail_q;
    ntests_d   = ntests_q;
    exit_d     = exit_q;
    capture    = 1'b0;
    cap_fail   = '0;

    case (state_q)
      HOLD: begin
        if (phase_q >= RST_LAST) begin
          state_d = RUN;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      RUN: begin
        jam_seen_d = jam_seen_q | i_jam;
        if (elapsed_q != TIMEOUT_V) begin
          elapsed_d = elapsed_q + 1'b1;
        end
        // All-jammed wins over the watchdog when both happen on the same cycle.
        if (&jam_seen_d) begin
          state_d = SETTLE;
          phase_d = '0;
        end else if (elapsed_d == TIMEOUT_V) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          capture   = 1'b1;
        end
      end
      SETTLE: begin
        if (phase_q >= SETTLE_LAST) begin
          state_d = DONE;
          phase_d = '0;
          capture = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE: begin
        if (i_start) begin
          state_d    = HOLD;
          phase_d    = '0;
          jam_seen_d = '0;
          elapsed_d  = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          fail_d     = '0;
          ntests_d   = '0;
          exit_d     = '0;
        end
      end
      default: state_d = HOLD;
    endcase

    if (capture) begin
      for (int k = 0; k < N_CORES; k++) begin
        cap_fail[k] = ~jam_seen_d[k] | (i_y[8*k +: 8] != 8'h00);
      end
      done_d   = 1'b1;
      ntests_d = i_x;
      exit_d   = i_y;
      fail_d   = cap_fail;
      pass_d   = (cap_fail == '0) && !timeout_d;
    end

    core_rst_d = (state_d == HOLD);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= HOLD;
      phase_q    <= '0;
      jam_seen_q <= '0;
      elapsed_q  <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fail_q     <= '0;
      ntests_q   <= '0;
      exit_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      jam_seen_q <= jam_seen_d;
      elapsed_q  <= elapsed_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      fail_q     <= fail_d;
      ntests_q   <= ntests_d;
      exit_q     <= exit_d;
    end
  end

  assign o_core_rst  = core_rst_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_timeout   = timeout_q;
  assign o_fail_mask = fail_q;
  assign o_ntests    = ntests_q;
  assign o_exit_code = exit_q;
  assign o_elapsed   = elapsed_q;

endmodule

// File: tb/tb_test_sequencer.sv
`timescale 1ns/1ps
// Directed bench for test_sequencer with 2 cores, 2-cycle hold, 4-cycle settle
// and a 20-cycle watchdog; inputs change and outputs are sampled on the falling edge.
module tb_test_sequencer;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [1:0]  jam;
  logic [15:0] xReg;
  logic [15:0] yReg;
  logic        coreRst;
  logic        done;
  logic        pass;
  logic        timeoutFlag;
  logic [1:0]  failMask;
  logic [15:0] nTests;
  logic [15:0] exitCode;
  logic [4:0]  elapsed;

  int nChecks = 0;
  int nPassed = 0;

  test_sequencer #(
    .N_CORES(2),
    .RST_CYCLES(2),
    .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_start(start),
    .i_jam(jam),
    .i_x(xReg),
    .i_y(yReg),
    .o_core_rst(coreRst),
    .o_done(done),
    .o_pass(pass),
    .o_timeout(timeoutFlag),
    .o_fail_mask(failMask),
    .o_ntests(nTests),
    .o_exit_code(exitCode),
    .o_elapsed(elapsed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the DUT at the falling edge right after it enters RUN (elapsed 0).
  task automatic doReset();
    start = 1'b0;
    jam   = 2'b00;
    rstN  = 1'b0;
    tick();
    rstN = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rstN  = 1'b1;
    start = 1'b0;
    jam   = 2'b00;
    xReg  = 16'h0000;
    yReg  = 16'h0000;
    #1 rstN = 1'b0;
    #1;
    nChecks++;
    if (coreRst !== 1'b1) $display("[TB] FAIL rst_core_rst: got %b expected 1", coreRst);
    else nPassed++;
    nChecks++;
    if ({done, pass, timeoutFlag} !== 3'b000)
      $display("[TB] FAIL rst_flags: got %b expected 000", {done, pass, timeoutFlag});
    else nPassed++;
    nChecks++;
    if ({failMask, nTests, exitCode, elapsed} !== 39'd0)
      $display("[TB] FAIL rst_results: got %h expected 0", {failMask, nTests, exitCode, elapsed});
    else nPassed++;
    tick();
    rstN = 1'b1;
    nChecks++;
    if (coreRst !== 1'b1) $display("[TB] FAIL hold_cycle1: got %b expected 1", coreRst);
    else nPassed++;
    tick();
    nChecks++;
    if (coreRst !== 1'b1) $display("[TB] FAIL hold_cycle2: got %b expected 1", coreRst);
    else nPassed++;
    tick();
    nChecks++;
    if ({coreRst, done, elapsed} !== 7'b0000000)
      $display("[TB] FAIL hold_exit: got %b expected 0000000", {coreRst, done, elapsed});
    else nPassed++;
    tick();
    nChecks++;
    if (elapsed !== 5'd1) $display("[TB] FAIL run_count: got %0d expected 1", elapsed);
    else nPassed++;
  endtask

  task automatic test_pass();
    doReset();
    xReg = 16'h2A2A;
    yReg = 16'h0000;
    for (int c = 1; c <= 5; c++) begin
      jam = (c == 5) ? 2'b11 : 2'b00;
      tick();
    end
    jam = 2'b00;
    nChecks++;
    if ({done, elapsed} !== {1'b0, 5'd5})
      $display("[TB] FAIL pass_enter_settle: got done=%b elapsed=%0d expected done=0 elapsed=5", done, elapsed);
    else nPassed++;
    repeat (3) tick();
    nChecks++;
    if (done !== 1'b0) $display("[TB] FAIL pass_settle_len: got done=%b expected 0", done);
    else nPassed++;
    tick();
    nChecks++;
    if ({done, pass, timeoutFlag} !== 3'b110)
      $display("[TB] FAIL pass_flags: got %b expected 110", {done, pass, timeoutFlag});
    else nPassed++;
    nChecks++;
    if ({failMask, nTests, elapsed} !== {2'b00, 16'h2A2A, 5'd5})
      $display("[TB] FAIL pass_results: got mask=%b ntests=%h elapsed=%0d expected mask=00 ntests=2a2a elapsed=5", failMask, nTests, elapsed);
    else nPassed++;
  endtask

  task automatic test_exit_code();
    doReset();
    xReg = 16'h2A2A;
    yReg = 16'h0300;
    for (int c = 1; c <= 5; c++) begin
      jam = (c == 5) ? 2'b11 : 2'b00;
      tick();
    end
    jam = 2'b00;
    repeat (4) tick();
    nChecks++;
    if ({done, pass, timeoutFlag} !== 3'b100)
      $display("[TB] FAIL exit_flags: got %b expected 100", {done, pass, timeoutFlag});
    else nPassed++;
    nChecks++;
    if ({failMask, exitCode} !== {2'b10, 16'h0300})
      $display("[TB] FAIL exit_results: got mask=%b exit=%h expected mask=10 exit=0300", failMask, exitCode);
    else nPassed++;
  endtask

  task automatic test_timeout();
    doReset();
    xReg = 16'h0102;
    yReg = 16'h0000;
    for (int c = 1; c <= 19; c++) begin
      jam = (c == 2) ? 2'b01 : 2'b00;
      tick();
    end
    nChecks++;
    if ({done, elapsed} !== {1'b0, 5'd19})
      $display("[TB] FAIL timeout_pre: got done=%b elapsed=%0d expected done=0 elapsed=19", done, elapsed);
    else nPassed++;
    jam = 2'b00;
    tick();
    nChecks++;
    if ({done, pass, timeoutFlag} !== 3'b101)
      $display("[TB] FAIL timeout_flags: got %b expected 101", {done, pass, timeoutFlag});
    else nPassed++;
    nChecks++;
    if ({failMask, nTests, elapsed} !== {2'b10, 16'h0102, 5'd20})
      $display("[TB] FAIL timeout_results: got mask=%b ntests=%h elapsed=%0d expected mask=10 ntests=0102 elapsed=20", failMask, nTests, elapsed);
    else nPassed++;
    jam = 2'b11;
    tick();
    nChecks++;
    if ({done, timeoutFlag, failMask, elapsed, coreRst} !== {1'b1, 1'b1, 2'b10, 5'd20, 1'b0})
      $display("[TB] FAIL timeout_hold: got done=%b to=%b mask=%b elapsed=%0d rst=%b expected 1 1 10 20 0", done, timeoutFlag, failMask, elapsed, coreRst);
    else nPassed++;
    jam = 2'b00;
  endtask

  task automatic test_timeout_priority();
    doReset();
    xReg = 16'h0000;
    yReg = 16'h0000;
    for (int c = 1; c <= 20; c++) begin
      jam = (c == 20) ? 2'b11 : 2'b01;
      tick();
    end
    jam = 2'b00;
    nChecks++;
    if ({done, timeoutFlag, elapsed} !== {1'b0, 1'b0, 5'd20})
      $display("[TB] FAIL prio_settle: got done=%b to=%b elapsed=%0d expected 0 0 20", done, timeoutFlag, elapsed);
    else nPassed++;
    repeat (4) tick();
    nChecks++;
    if ({done, pass, timeoutFlag, failMask, elapsed} !== {3'b110, 2'b00, 5'd20})
      $display("[TB] FAIL prio_done: got flags=%b mask=%b elapsed=%0d expected 110 00 20", {done, pass, timeoutFlag}, failMask, elapsed);
    else nPassed++;
  endtask

  task automatic test_sticky();
    doReset();
    xReg = 16'h0505;
    yReg = 16'h0000;
    for (int c = 1; c <= 8; c++) begin
      jam = (c == 3) ? 2'b01 : (c == 8) ? 2'b10 : 2'b00;
      tick();
      if (c == 7) begin
        nChecks++;
        if ({done, elapsed} !== {1'b0, 5'd7})
          $display("[TB] FAIL sticky_run: got done=%b elapsed=%0d expected 0 7", done, elapsed);
        else nPassed++;
      end
    end
    jam = 2'b00;
    tick();
    nChecks++;
    if (elapsed !== 5'd8) $display("[TB] FAIL sticky_freeze: got %0d expected 8", elapsed);
    else nPassed++;
    repeat (3) tick();
    nChecks++;
    if ({done, pass, timeoutFlag, failMask, elapsed} !== {3'b110, 2'b00, 5'd8})
      $display("[TB] FAIL sticky_done: got flags=%b mask=%b elapsed=%0d expected 110 00 8", {done, pass, timeoutFlag}, failMask, elapsed);
    else nPassed++;
  endtask

  task automatic test_reset_mid_settle();
    doReset();
    xReg = 16'h7777;
    yReg = 16'h0000;
    for (int c = 1; c <= 5; c++) begin
      jam = (c == 5) ? 2'b11 : 2'b00;
      tick();
    end
    jam = 2'b00;
    tick();
    tick();
    rstN = 1'b0;
    #1;
    nChecks++;
    if ({coreRst, done, elapsed} !== {1'b1, 1'b0, 5'd0})
      $display("[TB] FAIL midrst_clear: got rst=%b done=%b elapsed=%0d expected 1 0 0", coreRst, done, elapsed);
    else nPassed++;
    tick();
    rstN = 1'b1;
    tick();
    nChecks++;
    if (coreRst !== 1'b1) $display("[TB] FAIL midrst_hold: got %b expected 1", coreRst);
    else nPassed++;
    tick();
    nChecks++;
    if ({coreRst, done, nTests} !== {1'b0, 1'b0, 16'h0000})
      $display("[TB] FAIL midrst_run: got rst=%b done=%b ntests=%h expected 0 0 0000", coreRst, done, nTests);
    else nPassed++;
  endtask

  task automatic test_start();
    doReset();
    xReg  = 16'h1234;
    yReg  = 16'h0000;
    start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      jam = (c == 3) ? 2'b11 : 2'b00;
      tick();
      if (c == 2) begin
        nChecks++;
        if ({coreRst, elapsed} !== {1'b0, 5'd2})
          $display("[TB] FAIL start_in_run: got rst=%b elapsed=%0d expected 0 2", coreRst, elapsed);
        else nPassed++;
      end
    end
    jam = 2'b00;
    tick();
    tick();
    start = 1'b0;
    tick();
    tick();
    nChecks++;
    if ({done, pass, nTests, elapsed} !== {2'b11, 16'h1234, 5'd3})
      $display("[TB] FAIL start_done: got done=%b pass=%b ntests=%h elapsed=%0d expected 1 1 1234 3", done, pass, nTests, elapsed);
    else nPassed++;
    tick();
    nChecks++;
    if (done !== 1'b1) $display("[TB] FAIL start_done_hold: got %b expected 1", done);
    else nPassed++;
    start = 1'b1;
    tick();
    start = 1'b0;
    nChecks++;
    if ({coreRst, done, pass, timeoutFlag} !== 4'b1000)
      $display("[TB] FAIL restart_flags: got %b expected 1000", {coreRst, done, pass, timeoutFlag});
    else nPassed++;
    nChecks++;
    if ({failMask, nTests, exitCode, elapsed} !== 39'd0)
      $display("[TB] FAIL restart_clear: got %h expected 0", {failMask, nTests, exitCode, elapsed});
    else nPassed++;
    tick();
    nChecks++;
    if (coreRst !== 1'b1) $display("[TB] FAIL restart_hold2: got %b expected 1", coreRst);
    else nPassed++;
    tick();
    nChecks++;
    if (coreRst !== 1'b0) $display("[TB] FAIL restart_run: got %b expected 0", coreRst);
    else nPassed++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_exit_code();
    test_timeout();
    test_timeout_priority();
    test_sticky();
    test_reset_mid_settle();
    test_start();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 SHALL have parameter N_CORES, default 1, number of cores under test (1..8).
REQ-002 SHALL have parameter RST_CYCLES, default 2, core-reset hold length in cycles (>=1).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 50, wait from all-jammed to capture (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2500, RUN-state watchdog limit (>=1); CNT_W = $clog2(TIMEOUT_CYCLES+1).
REQ-005 SHALL have port i_clk, input, 1, single clock, rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_start, input, 1, restart request, honoured only in DONE.
REQ-008 SHALL have port i_jam, input, N_CORES, per-core JAM indication.
REQ-009 SHALL have port i_x, input, 8*N_CORES, per-core X register; core k at bits [8k+7:8k].
REQ-010 SHALL have port i_y, input, 8*N_CORES, per-core Y register (exit code); same packing.
REQ-011 SHALL have port o_core_rst, output, 1, active-high reset to cores.
REQ-012 SHALL have ports o_done, o_pass, o_timeout, output, 1 each, result flags.
REQ-013 SHALL have port o_fail_mask, output, N_CORES, per-core failure bit.
REQ-014 SHALL have ports o_ntests and o_exit_code, output, 8*N_CORES each, captured X and Y.
REQ-015 SHALL have port o_elapsed, output, CNT_W, cycles spent in RUN.

Function
REQ-016 SHALL implement FSM states HOLD, RUN, SETTLE, DONE; every output registered.
REQ-017 HOLD: o_core_rst=1 for exactly RST_CYCLES cycles, then -> RUN; o_core_rst=0 outside HOLD.
REQ-018 RUN: o_elapsed increments by 1 each cycle; per-core sticky jam_seen[k] set when i_jam[k]=1, cleared only on entry to HOLD.
REQ-019 RUN: when all bits of (jam_seen | i_jam) are 1 -> SETTLE next cycle; o_elapsed freezes.
REQ-020 RUN: when o_elapsed reaches TIMEOUT_CYCLES without all-jammed -> DONE with o_timeout=1; all-jammed in the same cycle has priority (-> SETTLE, o_timeout=0).
REQ-021 SETTLE: lasts exactly SETTLE_CYCLES cycles; i_jam ignored; watchdog stopped.
REQ-022 Capture on last SETTLE edge (or timeout edge): o_ntests<=i_x, o_exit_code<=i_y for all cores.
REQ-023 o_fail_mask[k] SHALL be 1 if captured Y of core k !=0 or jam_seen[k]=0 at capture.
REQ-024 o_pass SHALL equal (o_fail_mask==0) and !o_timeout; valid only with o_done.
REQ-025 DONE: o_done=1, all results held stable; i_start=1 -> HOLD next cycle, clearing o_done, o_pass, o_timeout, o_fail_mask, o_ntests, o_exit_code, o_elapsed.
REQ-026 i_start SHALL be ignored in HOLD, RUN, SETTLE.
REQ-027 Counters SHALL saturate, never wrap.

Reset
REQ-028 i_rst_n=0 SHALL asynchronously force state HOLD with hold counter 0, o_core_rst=1, all other outputs 0, jam_seen 0.
REQ-029 Reset asserted in any state (incl. mid-SETTLE) SHALL discard partial results; after release HOLD runs full RST_CYCLES.

Verification (N_CORES=2, RST_CYCLES=2, SETTLE_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-030 Release i_rst_n -> o_core_rst=1 for exactly 2 cycles, then 0; all result outputs 0.
REQ-031 Both cores i_jam=1 at RUN cycle 5, i_x=0x2A2A, i_y=0x0000 -> o_done 5 cycles later (4 SETTLE + 1), o_pass=1, o_fail_mask=00, o_ntests=0x2A2A, o_elapsed=5.
REQ-032 Same but core 1 Y=0x03 -> o_pass=0, o_fail_mask=10, o_exit_code=0x0300.
REQ-033 Core 1 never jams -> o_done at o_elapsed=20, o_timeout=1, o_pass=0, o_fail_mask=10; all-jam at cycle 20 instead -> o_timeout=0, SETTLE.
REQ-034 Core 0 one-cycle jam pulse at RUN cycle 3, core 1 jam at cycle 8 -> sticky; SETTLE starts after cycle 8, o_elapsed=8, o_pass=1.
REQ-035 i_rst_n low mid-SETTLE -> outputs cleared immediately; i_start in RUN ignored; i_start in DONE -> HOLD with o_done=0 next cycle.
